// File: rtl/sm_ahb_timer.sv
// AHB-Lite zero-wait-state timer: prescaled 32-bit up-counter, compare with sticky
// match flag, optional auto-reload and a level interrupt.
module sm_ahb_timer #(
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        irq
);

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_PRESC   = 3'd1;
    localparam logic [2:0] A_COUNT   = 3'd2;
    localparam logic [2:0] A_COMPARE = 3'd3;
    localparam logic [2:0] A_STATUS  = 3'd4;

    logic               valid_q, valid_d;
    logic               write_q, write_d;
    logic [2:0]         addr_q, addr_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic               match_q, match_d;

    logic wr_en, wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
    logic tick, hit;

    logic unused_haddr;
    assign unused_haddr = ^{HADDR[31:5], HADDR[1:0]};

    assign wr_en      = valid_q & write_q;
    assign wr_ctrl    = wr_en & (addr_q == A_CTRL);
    assign wr_presc   = wr_en & (addr_q == A_PRESC);
    assign wr_count   = wr_en & (addr_q == A_COUNT);
    assign wr_compare = wr_en & (addr_q == A_COMPARE);
    assign wr_status  = wr_en & (addr_q == A_STATUS);

    // A bus write to COUNT swallows a coincident tick, including its compare.
    assign tick = ctrl_q[0] & (pcnt_q == presc_q);
    assign hit  = tick & ~wr_count & (count_q == compare_q);

    always_comb begin
        valid_d   = HSEL & HTRANS[1] & HREADY;
        write_d   = write_q;
        addr_d    = addr_q;
        if (valid_d) begin
            write_d = HWRITE;
            addr_d  = HADDR[4:2];
        end

        ctrl_d    = wr_ctrl    ? HWDATA[2:0]         : ctrl_q;
        presc_d   = wr_presc   ? HWDATA[PRESC_W-1:0] : presc_q;
        compare_d = wr_compare ? HWDATA              : compare_q;

        pcnt_d = pcnt_q;
        if (wr_ctrl || wr_presc || tick)
            pcnt_d = '0;
        else if (ctrl_q[0])
            pcnt_d = pcnt_q + PRESC_W'(1);

        count_d = count_q;
        if (wr_count)
            count_d = HWDATA;
        else if (tick)
            count_d = (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;

        // A match set in the same cycle as a W1C takes priority.
        match_d = match_q;
        if (wr_status && HWDATA[0])
            match_d = 1'b0;
        if (hit)
            match_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            ctrl_q    <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            count_q   <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (valid_q && !write_q) begin
            case (addr_q)
                A_CTRL:    HRDATA = {29'd0, ctrl_q};
                A_PRESC:   HRDATA = 32'(presc_q);
                A_COUNT:   HRDATA = count_q;
                A_COMPARE: HRDATA = compare_q;
                A_STATUS:  HRDATA = {31'd0, match_q};
                default:   HRDATA = 32'd0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign irq       = match_q & ctrl_q[2];

endmodule

// File: tb/tb_sm_ahb_timer.sv
// Self-checking bench for sm_ahb_timer: register table, directed timing sequences
// and randomized bus traffic against a behavioural reference model.
module tb_sm_ahb_timer;

    localparam int PW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HSEL = 1'b0;
    logic [1:0]  HTRANS = 2'd0;
    logic        HWRITE = 1'b0;
    logic [31:0] HADDR = 32'd0;
    logic [31:0] HWDATA = 32'd0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP, irq;

    sm_ahb_timer #(.PRESC_W(PW)) dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .irq(irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model: tick happens on every (PRESC+1)-th enabled cycle since the
    // last CTRL/PRESC write, tracked as an unbounded enabled-cycle count.
    logic [31:0] m_ctrl = 0, m_presc = 0, m_count = 0, m_cmp = 0;
    bit          m_match = 0;
    longint      m_since = 0;
    bit          m_pv = 0, m_pw = 0;
    int          m_pa = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_reg(input int a);
        case (a)
            0: return m_ctrl;
            1: return m_presc;
            2: return m_count;
            3: return m_cmp;
            4: return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_update(input bit r, input bit hs, input logic [1:0] ht, input bit hw,
                            input logic [31:0] ha, input bit hr, input logic [31:0] hd);
        bit wr, tick, hit, cwr;
        if (r) begin
            m_ctrl = 0; m_presc = 0; m_count = 0; m_cmp = 0; m_match = 0;
            m_since = 0; m_pv = 0; m_pw = 0; m_pa = 0;
            return;
        end
        wr   = m_pv && m_pw;
        cwr  = wr && m_pa == 2;
        tick = m_ctrl[0] && ((m_since % (longint'(m_presc) + 1)) == longint'(m_presc));
        hit  = tick && !cwr && (m_count == m_cmp);
        if (cwr) m_count = hd;
        else if (tick) m_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
        if (hit) m_match = 1;
        else if (wr && m_pa == 4 && hd[0]) m_match = 0;
        if (wr && (m_pa == 0 || m_pa == 1)) m_since = 0;
        else if (m_ctrl[0]) m_since++;
        if (wr && m_pa == 0) m_ctrl = hd & 32'h7;
        if (wr && m_pa == 1) m_presc = hd & ((32'd1 << PW) - 1);
        if (wr && m_pa == 3) m_cmp = hd;
        m_pv = hs && ht[1] && hr;
        if (m_pv) begin
            m_pw = hw;
            m_pa = int'(ha[4:2]);
        end
    endtask

    // Check outputs against the model, then advance one clock in both.
    task automatic step();
        logic [31:0] exp_rd;
        #2;
        if (chk_en) begin
            exp_rd = (m_pv && !m_pw) ? m_reg(m_pa) : 32'd0;
            chk("hrdata_model", HRDATA, exp_rd);
            chk("irq_model", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
            chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
            chk("hresp", {31'd0, HRESP}, 32'd0);
        end
        @(posedge clk);
        m_update(rst, HSEL, HTRANS, HWRITE, HADDR, HREADY, HWDATA);
        cyc++;
        #1;
        chk_en = 1'b1;
    endtask

    task automatic addr_ph(input logic [31:0] a, input bit w);
        HSEL = 1; HTRANS = 2'b10; HWRITE = w; HADDR = a; HREADY = 1;
    endtask

    task automatic idle();
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_ph(a, 1); step();
        idle(); HWDATA = d; step();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr_ph(a, 0); step();
        idle(); d = HRDATA; step();
    endtask

    task automatic b2b(input logic [31:0] a1, input bit w1, input logic [31:0] d1,
                       input logic [31:0] a2, input bit w2, input logic [31:0] d2,
                       output logic [31:0] r2);
        addr_ph(a1, w1); step();
        addr_ph(a2, w2); HWDATA = d1; step();
        idle(); HWDATA = d2; r2 = HRDATA; step();
    endtask

    task automatic do_reset();
        rst = 1; idle(); step(); step(); rst = 0;
    endtask

    task automatic wait_irq(input int bound, output bit seen);
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            seen = irq;
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          write;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] r;
        bit seen;
        int t1;

        tbl = '{
            '{32'h00, 0, 0, 0}, '{32'h04, 0, 0, 0}, '{32'h08, 0, 0, 0}, '{32'h0C, 0, 0, 0},
            '{32'h10, 0, 0, 0}, '{32'h14, 0, 0, 0}, '{32'h18, 0, 0, 0}, '{32'h1C, 0, 0, 0},
            '{32'h04, 1, 32'h12345, 0},    '{32'h04, 0, 0, 32'h2345},
            '{32'h0C, 1, 32'hDEADBEEF, 0}, '{32'h0C, 0, 0, 32'hDEADBEEF},
            '{32'h08, 1, 32'h55, 0},       '{32'h08, 0, 0, 32'h55},
            '{32'h00, 1, 32'hF8, 0},       '{32'h00, 0, 0, 32'h0},
            '{32'h18, 1, 32'hFFFF, 0},     '{32'h18, 0, 0, 32'h0},
            '{32'h10, 1, 32'h1, 0},        '{32'h10, 0, 0, 32'h0}
        };

        // Reset and register map
        do_reset();
        chk("irq_after_reset", {31'd0, irq}, 32'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].write) wr(tbl[i].addr, tbl[i].data);
            else begin
                rd(tbl[i].addr, r);
                chk($sformatf("table[%0d]", i), r, tbl[i].exp);
            end
        end

        // Reset during a write data phase discards the write
        addr_ph(32'h0C, 1); step();
        idle(); HWDATA = 32'h77; rst = 1; step(); rst = 0;
        rd(32'h0C, r); chk("reset_mid_write", r, 32'd0);

        // Prescale: PRESC=3, increments every 4 clocks
        do_reset();
        wr(32'h04, 3); wr(32'h08, 0); wr(32'h00, 1);
        for (int k = 1; k <= 40; k++) begin
            addr_ph(32'h08, 0); step();
            chk("presc_stream", HRDATA, 32'(k / 4));
        end
        idle(); step();
        wr(32'h00, 0);
        rd(32'h08, r); chk("presc_final", r, 32'd10);

        // Compare + auto-reload with irq
        do_reset();
        wr(32'h04, 0); wr(32'h0C, 5); wr(32'h00, 7);
        for (int k = 1; k <= 12; k++) begin
            addr_ph(32'h08, 0); step();
            chk("reload_seq", HRDATA, 32'(k % 6));
        end
        idle(); step();
        wr(32'h10, 1);
        chk("irq_w1c", {31'd0, irq}, 32'd0);
        wait_irq(20, seen); chk("irq_rise1", {31'd0, seen}, 32'd1);
        t1 = cyc;
        wr(32'h10, 1);
        chk("irq_w1c2", {31'd0, irq}, 32'd0);
        wait_irq(20, seen); chk("irq_rise2", {31'd0, seen}, 32'd1);
        chk("irq_period", 32'(cyc - t1), 32'd6);

        // Free-run wrap, match only at 0x10
        do_reset();
        wr(32'h04, 0); wr(32'h0C, 32'h10); wr(32'h08, 32'hFFFFFFFE); wr(32'h00, 1);
        for (int k = 1; k <= 24; k++) begin
            addr_ph(k <= 3 ? 32'h08 : 32'h10, 0); step();
            if (k <= 3) chk("wrap_count", HRDATA, 32'hFFFFFFFE + 32'(k));
            else        chk("wrap_status", HRDATA, {31'd0, k >= 19});
        end
        idle(); step();

        // Collisions
        do_reset();
        wr(32'h04, 0); wr(32'h0C, 32'h200); wr(32'h00, 1);
        b2b(32'h08, 1, 32'h100, 32'h08, 0, 0, r); chk("count_wr_vs_tick", r, 32'h100);
        b2b(32'h08, 1, 32'h200, 32'h10, 1, 32'h1, r);
        rd(32'h10, r); chk("w1c_vs_match", r, 32'd1);
        wr(32'h10, 1);
        rd(32'h10, r); chk("w1c_plain", r, 32'd0);

        // Bus protocol
        do_reset();
        b2b(32'h0C, 1, 32'hA5A5, 32'h0C, 0, 0, r); chk("b2b_compare", r, 32'hA5A5);
        rd(32'h18, r); chk("read_0x18", r, 32'd0);
        HSEL = 1; HTRANS = 2'b00; HWRITE = 1; HADDR = 32'h0C; step();
        idle(); HWDATA = 32'h1234; step();
        HSEL = 0; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0C; step();
        idle(); HWDATA = 32'h2345; step();
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0C; HREADY = 0; step();
        idle(); HREADY = 1; HWDATA = 32'h3456; step();
        rd(32'h0C, r); chk("no_xfer_compare", r, 32'hA5A5);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst    = ($urandom_range(0, 299) == 0);
            HSEL   = ($urandom_range(0, 7) != 0);
            HTRANS = 2'($urandom);
            HWRITE = 1'($urandom);
            HADDR  = {$urandom_range(0, 7) == 0 ? 27'($urandom) : 27'd0,
                      3'($urandom_range(0, 7)), 2'($urandom)};
            HREADY = ($urandom_range(0, 9) != 0);
            case (m_pa)
                0: HWDATA = 32'($urandom_range(0, 7));
                1: HWDATA = 32'($urandom_range(0, 3));
                2, 3: HWDATA = 32'($urandom_range(0, 12));
                4: HWDATA = 32'($urandom_range(0, 1));
                default: HWDATA = $urandom;
            endcase
            step();
        end
        rst = 0; idle(); HREADY = 1; step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
